// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and buffers returned {pc,inst} pairs for the IF/ID register.
// EX redirects flush the buffer and discard the in-flight response (drop flag).
// Optional feature macro: IF_MISALIGN_TRAP_EN. When it is defined, a redirect to
// a non-word-aligned target pushes a single trap marker entry instead of fetching.
module if_fetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              misalign_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              drop_q, drop_d;
    logic              trap_hold;

    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] fpc_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fpc_d   [FIFO_DEPTH];
    logic [DATA_W-1:0] finst_q [FIFO_DEPTH];
    logic [DATA_W-1:0] finst_d [FIFO_DEPTH];
    logic              fmis_q  [FIFO_DEPTH];
    logic              fmis_d  [FIFO_DEPTH];

    logic              push, pop;

    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic [DATA_W-1:0] oinst_q, oinst_d;
    logic              omis_q, omis_d;

`ifdef IF_MISALIGN_TRAP_EN
    logic              trap_q, trap_d;

    // Trap state: holds the FSM idle after a misaligned redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap_hold = trap_q;
`else
    logic              unused_jump_lsb;

    assign trap_hold       = 1'b0;
    assign unused_jump_lsb = ^jump_addr_i[1:0];
`endif

    // Next-state: redirect, FIFO push/pop, fetch FSM and registered output images
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        drop_d      = drop_q;
`ifdef IF_MISALIGN_TRAP_EN
        trap_d      = trap_q;
`endif
        wr_d        = wr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        fpc_d       = fpc_q;
        finst_d     = finst_q;
        fmis_d      = fmis_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (jump_en_i) begin
            // A response is still owed if one was outstanding and did not land this cycle
            drop_d = ((state_q == S_WAIT) && !mem_rvalid_i)
                   || ((state_q == S_ISSUE) && mem_gnt_i)
                   || (drop_q && !mem_rvalid_i);
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            pc_d    = {jump_addr_i[ADDR_W-1:2], 2'b00};
            state_d = drop_d ? S_IDLE : S_ISSUE;
`ifdef IF_MISALIGN_TRAP_EN
            trap_d  = 1'b0;
            if (jump_addr_i[1:0] != 2'b00) begin
                trap_d     = 1'b1;
                state_d    = S_IDLE;
                fpc_d[0]   = jump_addr_i;
                finst_d[0] = DATA_W'(32'h0000_0013);
                fmis_d[0]  = 1'b1;
                wr_d       = PTR_W'(1);
                cnt_d      = CNT_W'(1);
            end
`endif
        end else begin
            pop  = valid_q && ready_i;
            push = (state_q == S_WAIT) && mem_rvalid_i;
            if (drop_q && mem_rvalid_i) begin
                drop_d = 1'b0;
            end
            if (push) begin
                fpc_d[wr_q]   = issued_pc_q;
                finst_d[wr_q] = mem_rdata_i;
                fmis_d[wr_q]  = 1'b0;
                wr_d          = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

            unique case (state_q)
                S_IDLE: begin
                    if (!drop_d && !trap_hold && (cnt_d < CNT_W'(FIFO_DEPTH))) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt_i) begin
                        issued_pc_d = pc_q;
                        pc_d        = pc_q + ADDR_W'(4);
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_d = (cnt_d < CNT_W'(FIFO_DEPTH)) ? S_ISSUE : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        req_d   = (state_d == S_ISSUE);
        addr_d  = pc_d;
        valid_d = (cnt_d != '0);
        opc_d   = valid_d ? fpc_d[rd_d]   : '0;
        oinst_d = valid_d ? finst_d[rd_d] : '0;
        omis_d  = valid_d ? fmis_d[rd_d]  : 1'b0;
    end

    // State, FIFO storage and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            drop_q      <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fpc_q[i]   <= '0;
                finst_q[i] <= '0;
                fmis_q[i]  <= 1'b0;
            end
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            valid_q     <= 1'b0;
            opc_q       <= '0;
            oinst_q     <= '0;
            omis_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            drop_q      <= drop_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            fpc_q       <= fpc_d;
            finst_q     <= finst_d;
            fmis_q      <= fmis_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            opc_q       <= opc_d;
            oinst_q     <= oinst_d;
            omis_q      <= omis_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign valid_o    = valid_q;
    assign pc_o       = opc_q;
    assign inst_o     = oinst_q;
    assign misalign_o = omis_q;

endmodule
